uart_param_transceiver: RTL and testbench
=========================================

Name: uart_param_transceiver

Overview:
- Parametrised full-duplex UART: one Tx serialiser and one Rx deserialiser, independent of each other, sharing one clock.
- Successor to the fixed 8-bit, even-parity, single-stop UART.
- Adds:
  - configurable data width, parity mode (none/even/odd), stop-bit count and oversampling ratio;
  - mid-bit Rx sampling with false-start rejection;
  - separate parity- and framing-error flags.
- Used standalone or in Tx->Rx loopback for self-test.

Parameters:
- DATA_WIDTH, 8, data bits per frame, legal 5..9, sent LSB first.
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- CLOCKS_PER_BIT, 8, clk cycles per bit period, even, >=4.
- NUMBER_OF_RX_SYNCHRONIZERS, 3, FF stages on serial_in, >=2.

Ports:
- clk  input  1  single clock for Tx and Rx.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- enable  input  1  Tx start request; accepted only when o_busy==0.
- i_data  input  DATA_WIDTH  Tx payload, captured on acceptance.
- o_busy  output  1  Tx frame in progress.
- serial_out  output  1  Tx line, idle high.
- serial_in  input  1  Rx line, asynchronous, idle high.
- received_data  output  DATA_WIDTH  last received payload.
- data_is_valid  output  1  one-cycle pulse when a frame completes.
- rx_parity_error  output  1  parity mismatch on last frame.
- rx_framing_error  output  1  stop bit sampled low on last frame.
- rx_busy  output  1  Rx frame in progress.

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous and active-high.
  - Reset values: serial_out=1, o_busy=0, received_data=0, data_is_valid=0, both error flags 0, rx_busy=0.
  - All synchroniser stages reset to 1.
  - Tx and Rx FSMs reset to IDLE.
  - Reset mid-frame: frame aborted; serial_out=1 from the next cycle; no data_is_valid pulse.
- Frame: P = (PARITY_MODE!=0). Length F = 1 + DATA_WIDTH + P + STOP_BITS bits.
  - Even parity bit = ^data. Odd parity bit = ~^data.
- Tx FSM (IDLE, START, DATA, PARITY, STOP):
  - enable=1 and o_busy=0 in cycle t: i_data captured; o_busy=1 and serial_out=0 from t+1.
  - Each bit is held exactly CLOCKS_PER_BIT cycles. Data is sent LSB first, then parity if P, then STOP_BITS ones.
  - o_busy stays high for exactly F*CLOCKS_PER_BIT cycles (t+1 .. t+F*CLOCKS_PER_BIT), then returns to 0.
  - enable while o_busy=1 is ignored.
  - enable in the first cycle with o_busy=0 starts the next frame back-to-back; no extra idle cycle.
- Rx synchroniser: serial_in passes through NUMBER_OF_RX_SYNCHRONIZERS FFs. The FSM sees only the last stage (rx_s).
- Rx FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE -> START on rx_s==0; rx_busy=1 from that cycle.
  - START: after CLOCKS_PER_BIT/2 cycles, resample rx_s.
    - rx_s==1: false start; return to IDLE; rx_busy=0; no pulse.
    - rx_s==0: go to DATA.
  - DATA: sample every CLOCKS_PER_BIT cycles thereafter (bit centre). DATA_WIDTH samples, LSB first.
  - PARITY (only if P): one sample.
  - STOP: sample the first stop bit only; a second stop bit is treated as idle line. Next cycle:
    - data_is_valid=1 for exactly one cycle;
    - received_data updated;
    - rx_parity_error = parity mismatch (always 0 when PARITY_MODE=0);
    - rx_framing_error = (stop sample==0);
    - FSM returns to IDLE; rx_busy=0.
  - Errors never suppress data_is_valid. Flags and received_data hold until the next pulse.
  - Stop sampled low (break): after the pulse, Rx waits in IDLE until rx_s==1 before arming for a new start bit.
- Latency: if the serial_in pin first goes low in cycle t0, data_is_valid is high in cycle t0 + NUMBER_OF_RX_SYNCHRONIZERS + CLOCKS_PER_BIT/2 + (1+DATA_WIDTH+P)*CLOCKS_PER_BIT + 1.
  - Loopback, defaults: enable accepted at t -> data_is_valid at t+89.
- Counters: bit-period counter width $clog2(CLOCKS_PER_BIT); bit-index counter width $clog2(F+1). Both wrap only via explicit reload, never by overflow.

Test Plan:
- Loopback, defaults, i_data=8'hA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,0,1 at 8 clk/bit; o_busy high 88 cycles; data_is_valid at t+89 with received_data=8'hA5; no errors.
- PARITY_MODE=2, STOP_BITS=2, DATA_WIDTH=7, i_data=7'h00 -> parity bit 1; o_busy high 11*8=88 cycles; loopback receives 7'h00, no errors.
- Rx-only, drive frame 8'h3C with inverted parity bit -> data_is_valid pulse, received_data=8'h3C, rx_parity_error=1, rx_framing_error=0; next good frame clears the flag.
- Rx-only, frame 8'h81 with stop bit 0, then line held low 40 cycles -> pulse with rx_framing_error=1; no second frame until the line returns high.
- serial_in low pulse of 2 cycles -> rx_busy pulses; no data_is_valid; Rx back in IDLE; next valid frame received correctly.
- enable pulsed again while o_busy=1, then reset asserted at bit 4 -> second request ignored; serial_out=1 and o_busy=0 the cycle after reset; no data_is_valid pulse.

Source files
------------

// File: rtl/uart_param_transceiver.sv
// Parametrised full-duplex UART: independent Tx serialiser and Rx deserialiser on one clock.
// Frame = start, DATA_WIDTH bits LSB first, optional parity, STOP_BITS stop bits.
module uart_param_transceiver #(
  parameter int DATA_WIDTH                 = 8,
  parameter int PARITY_MODE                = 1,
  parameter int STOP_BITS                  = 1,
  parameter int CLOCKS_PER_BIT             = 8,
  parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_is_valid,
  output logic                  rx_parity_error,
  output logic                  rx_framing_error,
  output logic                  rx_busy
);
  localparam int P  = (PARITY_MODE != 0) ? 1 : 0;
  localparam int F  = 1 + DATA_WIDTH + P + STOP_BITS;
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(F + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
    return (PARITY_MODE == 2) ? ~^d : ^d;
  endfunction

  // ---------------- Tx ----------------
  state_t                tx_state, tx_state_n;
  logic [CW-1:0]         tx_cnt, tx_cnt_n;
  logic [IW-1:0]         tx_idx, tx_idx_n;
  logic [DATA_WIDTH-1:0] tx_shreg, tx_shreg_n;
  logic                  tx_par, tx_par_n;
  logic                  tx_out_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shreg   <= '0;
      tx_par     <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      tx_state   <= tx_state_n;
      tx_cnt     <= tx_cnt_n;
      tx_idx     <= tx_idx_n;
      tx_shreg   <= tx_shreg_n;
      tx_par     <= tx_par_n;
      serial_out <= tx_out_n;
    end
  end

  // serial_out is registered: the next line level is decided together with the state change
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shreg_n = tx_shreg;
    tx_par_n   = tx_par;
    tx_out_n   = serial_out;
    if (tx_state == S_IDLE) begin
      tx_out_n = 1'b1;
      if (enable) begin
        tx_state_n = S_START;
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
        tx_shreg_n = i_data;
        tx_par_n   = parity_of(i_data);
        tx_out_n   = 1'b0;
      end
    end else if (tx_cnt != CNT_LAST) begin
      tx_cnt_n = tx_cnt + CW'(1);
    end else begin
      tx_cnt_n = '0;
      case (tx_state)
        S_START: begin
          tx_state_n = S_DATA;
          tx_idx_n   = '0;
          tx_out_n   = tx_shreg[0];
        end
        S_DATA: begin
          if (tx_idx == DATA_LAST) begin
            tx_idx_n = '0;
            if (P != 0) begin
              tx_state_n = S_PARITY;
              tx_out_n   = tx_par;
            end else begin
              tx_state_n = S_STOP;
              tx_out_n   = 1'b1;
            end
          end else begin
            tx_idx_n   = tx_idx + IW'(1);
            tx_shreg_n = tx_shreg >> 1;
            tx_out_n   = tx_shreg[1];
          end
        end
        S_PARITY: begin
          tx_state_n = S_STOP;
          tx_idx_n   = '0;
          tx_out_n   = 1'b1;
        end
        S_STOP: begin
          tx_out_n = 1'b1;
          if (tx_idx == STOP_LAST) tx_state_n = S_IDLE;
          else                     tx_idx_n   = tx_idx + IW'(1);
        end
        default: tx_state_n = S_IDLE;
      endcase
    end
  end

  assign o_busy = (tx_state != S_IDLE);

  // ---------------- Rx ----------------
  logic [NUMBER_OF_RX_SYNCHRONIZERS-1:0] rx_sync;
  logic                                  rx_s;

  always_ff @(posedge clk) begin
    if (reset) rx_sync <= '1;
    else       rx_sync <= {rx_sync[NUMBER_OF_RX_SYNCHRONIZERS-2:0], serial_in};
  end
  assign rx_s = rx_sync[NUMBER_OF_RX_SYNCHRONIZERS-1];

  state_t                rx_state, rx_state_n;
  logic [CW-1:0]         rx_cnt, rx_cnt_n;
  logic [IW-1:0]         rx_idx, rx_idx_n;
  logic [DATA_WIDTH-1:0] rx_shreg, rx_shreg_n;
  logic                  rx_par_bit, rx_par_bit_n;
  logic                  rx_hold, rx_hold_n;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic                  rx_valid_n, rx_perr_n, rx_ferr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state         <= S_IDLE;
      rx_cnt           <= '0;
      rx_idx           <= '0;
      rx_shreg         <= '0;
      rx_par_bit       <= 1'b0;
      rx_hold          <= 1'b0;
      received_data    <= '0;
      data_is_valid    <= 1'b0;
      rx_parity_error  <= 1'b0;
      rx_framing_error <= 1'b0;
    end else begin
      rx_state         <= rx_state_n;
      rx_cnt           <= rx_cnt_n;
      rx_idx           <= rx_idx_n;
      rx_shreg         <= rx_shreg_n;
      rx_par_bit       <= rx_par_bit_n;
      rx_hold          <= rx_hold_n;
      received_data    <= rx_data_n;
      data_is_valid    <= rx_valid_n;
      rx_parity_error  <= rx_perr_n;
      rx_framing_error <= rx_ferr_n;
    end
  end

  // rx_hold blocks re-arming after a break until the line has been seen high again
  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_idx_n     = rx_idx;
    rx_shreg_n   = rx_shreg;
    rx_par_bit_n = rx_par_bit;
    rx_hold_n    = rx_hold;
    rx_data_n    = received_data;
    rx_valid_n   = 1'b0;
    rx_perr_n    = rx_parity_error;
    rx_ferr_n    = rx_framing_error;
    case (rx_state)
      S_IDLE: begin
        if (rx_s) begin
          rx_hold_n = 1'b0;
        end else if (!rx_hold) begin
          rx_state_n = S_START;
          rx_cnt_n   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          rx_state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shreg_n = {rx_s, rx_shreg[DATA_WIDTH-1:1]};
          if (rx_idx == DATA_LAST) begin
            rx_idx_n   = '0;
            rx_state_n = (P != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_idx_n = rx_idx + IW'(1);
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n     = '0;
          rx_par_bit_n = rx_s;
          rx_state_n   = S_STOP;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        // only the first stop bit is sampled; any further stop bits look like idle line
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = S_IDLE;
          rx_valid_n = 1'b1;
          rx_data_n  = rx_shreg;
          rx_perr_n  = (P != 0) && (rx_par_bit != parity_of(rx_shreg));
          rx_ferr_n  = !rx_s;
          rx_hold_n  = !rx_s;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  assign rx_busy = (rx_state != S_IDLE);

endmodule

// File: tb/tb_uart_param_transceiver.sv
// Bench for uart_param_transceiver: default instance (switchable loopback) plus a
// 7-bit / odd-parity / 2-stop instance in fixed loopback.
module tb_uart_param_transceiver;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, loop = 1'b1, tb_line = 1'b1;
  logic [7:0] i_data = '0;
  logic o_busy, serial_out, rx_line, data_is_valid, rx_parity_error, rx_framing_error, rx_busy;
  logic [7:0] received_data;

  logic enable2 = 1'b0;
  logic [6:0] i_data2 = '0;
  logic o_busy2, serial_out2, valid2, perr2, ferr2, rx_busy2;
  logic [6:0] rdata2;

  int checks = 0, passed = 0, cyc = 0;
  int valid_cnt = 0, last_valid_cyc = 0;
  logic [9:0] sb[$];  // {parity_err, framing_err, data}

  assign rx_line = loop ? serial_out : tb_line;

  uart_param_transceiver dut (
    .clk(clk), .reset(reset), .enable(enable), .i_data(i_data), .o_busy(o_busy),
    .serial_out(serial_out), .serial_in(rx_line), .received_data(received_data),
    .data_is_valid(data_is_valid), .rx_parity_error(rx_parity_error),
    .rx_framing_error(rx_framing_error), .rx_busy(rx_busy));

  uart_param_transceiver #(.DATA_WIDTH(7), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .i_data(i_data2), .o_busy(o_busy2),
    .serial_out(serial_out2), .serial_in(serial_out2), .received_data(rdata2),
    .data_is_valid(valid2), .rx_parity_error(perr2), .rx_framing_error(ferr2),
    .rx_busy(rx_busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every data_is_valid pulse must match the oldest pending frame
  always @(negedge clk) begin
    if (data_is_valid) begin
      logic [9:0] e;
      valid_cnt++;
      last_valid_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL rx_unexpected: got data %h perr %b ferr %b, want no pulse",
                 received_data, rx_parity_error, rx_framing_error);
      end else begin
        e = sb.pop_front();
        if ({rx_parity_error, rx_framing_error, received_data} !== e)
          $display("FAIL rx_frame: got perr %b ferr %b data %h, want perr %b ferr %b data %h",
                   rx_parity_error, rx_framing_error, received_data, e[9], e[8], e[7:0]);
        else passed++;
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    logic [10:0] f;
    f = {stop, (^d) ^ flip, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      tb_line = f[b];
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({serial_out, o_busy, data_is_valid, rx_parity_error, rx_framing_error, rx_busy, received_data} !== 14'b10_0000_0000_0000)
      $display("FAIL reset_values: got so %b busy %b v %b pe %b fe %b rb %b data %h, want 1 0 0 0 0 0 00",
               serial_out, o_busy, data_is_valid, rx_parity_error, rx_framing_error, rx_busy, received_data);
    else passed++;
    checks++;
    if ({serial_out2, o_busy2, valid2, perr2, ferr2, rx_busy2, rdata2} !== 13'b1_0000_0000_0000)
      $display("FAIL reset_values2: got so %b busy %b v %b data %h, want 1 0 0 00", serial_out2, o_busy2, valid2, rdata2);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    int t, busy_n, v0;
    logic [10:0] bits;
    bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    loop = 1'b1; i_data = 8'hA5; enable = 1'b1; t = cyc; v0 = valid_cnt;
    sb.push_back({2'b00, 8'hA5});
    @(negedge clk); enable = 1'b0; i_data = 8'h00;
    busy_n = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_busy) busy_n++;
      if (k < 88 && k % 8 == 4) begin
        checks++;
        if (serial_out !== bits[k/8]) $display("FAIL a5_bit%0d: got %b want %b", k/8, serial_out, bits[k/8]);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (busy_n != 88) $display("FAIL a5_busy_len: got %0d want 88", busy_n); else passed++;
    for (int i = 0; i < 50 && valid_cnt == v0; i++) @(negedge clk);
    checks++;
    if (valid_cnt == v0 || last_valid_cyc - t != 89)
      $display("FAIL a5_latency: got %0d (pulses %0d) want 89", last_valid_cyc - t, valid_cnt - v0);
    else passed++;
  endtask

  task automatic test_odd_parity_2stop();
    int t, busy_n, vcyc;
    logic seen;
    logic [10:0] bits;
    logic [8:0] got;
    bits = {2'b11, 1'b1, 7'h00, 1'b0};
    i_data2 = 7'h00; enable2 = 1'b1; t = cyc; seen = 1'b0; vcyc = 0; got = '0;
    @(negedge clk); enable2 = 1'b0; i_data2 = 7'h7F;
    busy_n = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_busy2) busy_n++;
      if (valid2 && !seen) begin seen = 1'b1; vcyc = cyc; got = {perr2, ferr2, rdata2}; end
      if (k < 88 && k % 8 == 4 && (k/8 == 0 || k/8 >= 8)) begin
        checks++;
        if (serial_out2 !== bits[k/8]) $display("FAIL odd_bit%0d: got %b want %b", k/8, serial_out2, bits[k/8]);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (busy_n != 88) $display("FAIL odd_busy_len: got %0d want 88", busy_n); else passed++;
    checks++;
    if (!seen || got !== 9'b0 || vcyc - t != 81)
      $display("FAIL odd_rx: got seen %b word %h at +%0d, want seen 1 word 000 at +81", seen, got, vcyc - t);
    else passed++;
  endtask

  task automatic test_parity_error();
    int t0, v0;
    loop = 1'b0; t0 = cyc; v0 = valid_cnt;
    sb.push_back({2'b10, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 50 && valid_cnt == v0; i++) @(negedge clk);
    checks++;
    if (valid_cnt != v0 + 1 || last_valid_cyc - t0 != 88)
      $display("FAIL perr_pulse: got %0d pulses at +%0d, want 1 at +88", valid_cnt - v0, last_valid_cyc - t0);
    else passed++;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_parity_error !== 1'b1) $display("FAIL perr_hold: got %b want 1", rx_parity_error); else passed++;
    v0 = valid_cnt;
    sb.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 50 && valid_cnt == v0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (valid_cnt != v0 + 1 || rx_parity_error !== 1'b0)
      $display("FAIL perr_clear: got pulses %0d perr %b want 1 0", valid_cnt - v0, rx_parity_error);
    else passed++;
  endtask

  task automatic test_framing_break();
    int v0;
    loop = 1'b0; v0 = valid_cnt;
    sb.push_back({2'b01, 8'h81});
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if (valid_cnt != v0 + 1 || rx_busy !== 1'b0 || rx_framing_error !== 1'b1)
      $display("FAIL break_hold: got pulses %0d rx_busy %b ferr %b want 1 0 1", valid_cnt - v0, rx_busy, rx_framing_error);
    else passed++;
    tb_line = 1'b1;
    repeat (16) @(negedge clk);
    sb.push_back({2'b00, 8'h42});
    send_frame(8'h42, 1'b0, 1'b1);
    for (int i = 0; i < 50 && valid_cnt == v0 + 1; i++) @(negedge clk);
    checks++;
    if (valid_cnt != v0 + 2) $display("FAIL break_recover: got %0d pulses want 2", valid_cnt - v0); else passed++;
  endtask

  task automatic test_false_start();
    int v0;
    logic saw_busy;
    loop = 1'b0; v0 = valid_cnt; saw_busy = 1'b0;
    tb_line = 1'b0;
    repeat (2) @(negedge clk);
    tb_line = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rx_busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!saw_busy || valid_cnt != v0 || rx_busy !== 1'b0)
      $display("FAIL glitch: got saw_busy %b pulses %0d rx_busy %b want 1 0 0", saw_busy, valid_cnt - v0, rx_busy);
    else passed++;
    sb.push_back({2'b00, 8'hC3});
    send_frame(8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 50 && valid_cnt == v0; i++) @(negedge clk);
    checks++;
    if (valid_cnt != v0 + 1) $display("FAIL glitch_next: got %0d pulses want 1", valid_cnt - v0); else passed++;
  endtask

  task automatic test_back_to_back();
    int t, t2, v0;
    loop = 1'b1; v0 = valid_cnt;
    repeat (4) @(negedge clk);
    sb.push_back({2'b00, 8'h3C});
    i_data = 8'h3C; enable = 1'b1; t = cyc;
    @(negedge clk); enable = 1'b0;
    for (int i = 0; i < 120 && o_busy; i++) @(negedge clk);
    sb.push_back({2'b00, 8'hC5});
    i_data = 8'hC5; enable = 1'b1; t2 = cyc;
    @(negedge clk); enable = 1'b0;
    checks++;
    if (t2 - t != 89 || o_busy !== 1'b1 || serial_out !== 1'b0)
      $display("FAIL b2b_start: got gap %0d busy %b so %b want 89 1 0", t2 - t, o_busy, serial_out);
    else passed++;
    for (int i = 0; i < 200 && valid_cnt != v0 + 2; i++) @(negedge clk);
    checks++;
    if (valid_cnt != v0 + 2 || last_valid_cyc - t2 != 89)
      $display("FAIL b2b_rx: got %0d pulses last at +%0d want 2 at +89", valid_cnt - v0, last_valid_cyc - t2);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int t, v0;
    logic busy_seen;
    loop = 1'b1; v0 = valid_cnt; busy_seen = 1'b0;
    repeat (4) @(negedge clk);
    i_data = 8'h0F; enable = 1'b1; t = cyc;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) enable = 1'b0;
      if (k == 3) begin enable = 1'b1; i_data = 8'hF0; end
      if (k == 4) enable = 1'b0;
      if (k == 13 || k == 21 || k == 29 || k == 35) begin
        checks++;
        if (serial_out !== 1'b1 || o_busy !== 1'b1)
          $display("FAIL ignore_bit_k%0d: got so %b busy %b want 1 1", k, serial_out, o_busy);
        else passed++;
      end
      if (k == 35) reset = 1'b1;
      if (k == 36) begin
        reset = 1'b0;
        checks++;
        if (serial_out !== 1'b1 || o_busy !== 1'b0 || rx_busy !== 1'b0)
          $display("FAIL midreset: got so %b busy %b rx_busy %b want 1 0 0", serial_out, o_busy, rx_busy);
        else passed++;
      end
    end
    for (int k = 0; k < 120; k++) begin
      if (o_busy || !serial_out) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (valid_cnt != v0 || busy_seen)
      $display("FAIL midreset_quiet: got pulses %0d tx_activity %b want 0 0", valid_cnt - v0, busy_seen);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_a5();
    test_odd_parity_2stop();
    test_parity_error();
    test_framing_break();
    test_false_start();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending frames want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
